acc_sum9: RTL and testbench

ACC_SUM9 -- requirements
Module: acc_sum9

---
 rtl/acc_sum9_pkg.sv | 17 +
 rtl/acc_sum9_sat_clip.sv | 28 ++
 rtl/acc_sum9.sv | 105 ++++++++++
 tb/tb_acc_sum9.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_sum9_pkg.sv
// Shared definitions for the group-sum accumulator and its downstream divide-by-9 stage.
// Holds the FSM state type, accumulator headroom and default-width saturation limits.
package acc_sum9_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned SUM_W     = 32;
    localparam int unsigned ACC_GUARD = 5;
    localparam int unsigned ACC_W     = SUM_W + ACC_GUARD;

    localparam logic [SUM_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [SUM_W-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/acc_sum9_sat_clip.sv
// Signed IN_W -> OUT_W saturating clip; sat_o flags that the value was clipped.
module sat_clip #(
    parameter int unsigned IN_W  = 37,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  din_i,
    output logic [OUT_W-1:0] dout_o,
    output logic             sat_o
);

    logic [IN_W-OUT_W:0] top_bits;

    assign top_bits = din_i[IN_W-1:OUT_W-1];

    // The value fits when every bit above the result's MSB is a copy of the sign.
    always_comb begin
        sat_o  = !((&top_bits) || !(|top_bits));
        dout_o = din_i[OUT_W-1:0];
        if (sat_o) begin
            if (din_i[IN_W-1]) begin
                dout_o = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                dout_o = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/acc_sum9.sv
// Sums groups of N signed samples and offers the saturated W-bit total through a
// valid/ready handshake; a held result can be consumed in the same cycle a new group starts.
module acc_sum9
    import acc_sum9_pkg::*;
#(
    parameter int unsigned N = 9,
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_sat
);

    localparam int unsigned AW = W + ACC_GUARD;
    localparam int unsigned CW = $clog2(N);

    state_e          state_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic            alive_q;
    logic [W-1:0]    data_q;
    logic            sat_q;

    logic [AW-1:0]   samp_ext;
    logic [AW-1:0]   sum_d;
    logic [W-1:0]    clip_d;
    logic            clip_sat_d;
    logic            take;

    assign samp_ext = {{ACC_GUARD{in_data[W-1]}}, in_data};
    assign sum_d    = acc_q + samp_ext;

    // alive_q keeps in_ready low through reset and for the first edge after release.
    assign in_ready  = alive_q && !clear && ((state_q == ACCUM) || out_ready);
    assign take      = in_valid && in_ready;
    assign out_valid = (state_q == HOLD);
    assign out_data  = data_q;
    assign out_sat   = sat_q;

    sat_clip #(
        .IN_W  (AW),
        .OUT_W (W)
    ) u_clip (
        .din_i  (sum_d),
        .dout_o (clip_d),
        .sat_o  (clip_sat_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            alive_q <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (clear) begin
                state_q <= ACCUM;
                acc_q   <= '0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ACCUM: begin
                        if (take) begin
                            if (cnt_q == CW'(N - 1)) begin
                                state_q <= HOLD;
                                acc_q   <= '0;
                                cnt_q   <= '0;
                                data_q  <= clip_d;
                                sat_q   <= clip_sat_d;
                            end else begin
                                acc_q <= sum_d;
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                    HOLD: begin
                        // Consuming the result and accepting the first sample of the next group coincide.
                        if (out_ready) begin
                            state_q <= ACCUM;
                            if (take) begin
                                acc_q <= samp_ext;
                                cnt_q <= CW'(1);
                            end else begin
                                acc_q <= '0;
                                cnt_q <= '0;
                            end
                        end
                    end
                    default: state_q <= ACCUM;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acc_sum9.sv
// Randomised and directed bench for acc_sum9: a reference model predicts group sums into a
// queue and a negedge monitor compares handshakes and held results against it.
module tb_acc_sum9;

    localparam int unsigned N = 9;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_sat;

    always #5 clk = ~clk;

    acc_sum9 #(
        .N (N),
        .W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         s;
    } exp_t;

    exp_t        expq[$];
    int          n_vec = 0;
    int          n_err = 0;
    longint      msum;
    int unsigned mcnt;
    bit          mhold;
    bit          malive;
    bit          m_rdy;
    int unsigned n_out = 0;

    function automatic bit model_ready();
        return malive && !clear && (!mhold || out_ready);
    endfunction

    function automatic exp_t clip(input longint s);
        exp_t   e;
        longint maxv;
        longint minv;
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -maxv - 1;
        e.s  = 1'b1;
        if (s > maxv)      e.d = W'(maxv);
        else if (s < minv) e.d = W'(minv);
        else begin
            e.d = W'(s);
            e.s = 1'b0;
        end
        return e;
    endfunction

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chk_word(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: group bookkeeping with plain integer arithmetic.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mcnt = 0; msum = 0; mhold = 0; malive = 0;
            expq.delete();
        end else begin
            m_rdy = model_ready();
            if (clear) begin
                if (mhold && expq.size() > 0) void'(expq.pop_back());
                mhold = 0; mcnt = 0; msum = 0;
            end else if (mhold) begin
                if (out_ready) begin
                    mhold = 0;
                    if (in_valid) begin
                        msum = longint'($signed(in_data));
                        mcnt = 1;
                    end else begin
                        msum = 0;
                        mcnt = 0;
                    end
                end
            end else if (in_valid && m_rdy) begin
                msum += longint'($signed(in_data));
                mcnt++;
                if (mcnt == N) begin
                    expq.push_back(clip(msum));
                    mhold = 1; mcnt = 0; msum = 0;
                end
            end
            malive = 1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk_bit("rst_in_ready", in_ready, 1'b0);
            chk_bit("rst_out_valid", out_valid, 1'b0);
            chk_word("rst_out_data", out_data, '0);
            chk_bit("rst_out_sat", out_sat, 1'b0);
        end else begin
            chk_bit("in_ready", in_ready, model_ready());
            chk_bit("out_valid", out_valid, mhold);
            if (out_valid) begin
                if (expq.size() == 0) begin
                    chk_bit("result_expected", 1'b1, 1'b0);
                end else begin
                    chk_word("out_data", out_data, expq[0].d);
                    chk_bit("out_sat", out_sat, expq[0].s);
                    if (out_ready && !clear) begin
                        void'(expq.pop_front());
                        n_out++;
                    end
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic group(input logic [W-1:0] d, input int unsigned cnt, input logic ordy);
        for (int unsigned i = 0; i < cnt; i++) cyc(1'b1, d, ordy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);

        for (int unsigned i = 1; i <= 9; i++) cyc(1'b1, W'(i), 1'b1, 1'b0);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

        group(32'h7FFF_FFFF, 9, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        group(32'h8000_0000, 9, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        group(-32'sd5, 9, 1'b0);
        repeat (6) cyc(1'b1, 32'd11, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        group(32'd3, 9, 1'b1);
        group(32'd7, 9, 1'b1);
        repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

        group(32'd100, 4, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        group(32'd2, 9, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        group(32'd2, 8, 1'b1);
        cyc(1'b1, 32'd2, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        group(32'd1, 5, 1'b1);
        rst_n = 1'b0;
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b0);
        group(32'd1, 9, 1'b1);
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] d;
            case ($urandom_range(0, 3))
                0:       d = 32'h7FFF_FFFF;
                1:       d = 32'h8000_0000;
                2:       d = W'($urandom_range(0, 200)) - 32'd100;
                default: d = $urandom;
            endcase
            cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
        end
        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0);

        chk_word("queue_empty", W'(expq.size()), '0);
        chk_bit("outputs_seen", n_out > 20, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
